// File: rtl/uram_pkg.sv
// Shared types for the URAM burst reader: FSM states and the in-flight read tag.
package uram_pkg;

  localparam int RD_LATENCY_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/uram_skid_fifo.sv
// Synchronous FIFO with a registered head word; count includes the word on the output.
module uram_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic             pop;

  assign pop = rd_valid && rd_ready;

  always_comb begin
    rd_ptr_next = rd_ptr + PW'(pop);
    count_next  = count + CW'(wr_en) - CW'(pop);
  end

  // NOTE: storage carries no reset; only pointers and count define validity, so
  // clearing the array would add a reset net to every bit for no benefit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= (count_next != '0);
      // A write into an otherwise empty queue lands directly on the head register.
      if (count_next != '0)
        rd_data <= (wr_en && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/uram_burst_reader.sv
// Burst read engine for a fixed-latency URAM port: issues addresses under a credit
// limit and returns the words as a valid/ready stream with a last flag.
module uram_burst_reader
  import uram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 15,
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
  parameter int SKID_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  zero_pend;
  tag_t                  issue_tag;
  tag_t                  tag_sr [RD_LATENCY];
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  credit_ok;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  last_hs;
  logic                  fifo_last;

  // Reads already issued still own a FIFO slot, so they count against the depth.
  assign credit_ok = ((CW+1)'(fifo_count) + (CW+1)'(inflight)) < (CW+1)'(SKID_DEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = tag_sr[RD_LATENCY-1].valid;
  assign last_hs   = m_valid && m_ready && m_last;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    issue      = 1'b0;
    busy       = (state != IDLE) || zero_pend;
    done       = zero_pend;
    case (state)
      IDLE: begin
        cmd_ready = !zero_pend;
        if (accept && (cmd_len != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        issue = credit_ok;
        if (credit_ok && (remaining == LEN_WIDTH'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_hs) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      zero_pend  <= 1'b0;
      addr_q     <= '0;
      remaining  <= '0;
      ram_addr_b <= '0;
    end else begin
      state     <= state_next;
      zero_pend <= accept && (cmd_len == '0);
      if (accept) begin
        addr_q    <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        ram_addr_b <= addr_q;
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        remaining  <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // issue_tag rides alongside ram_addr_b; tag_sr then tracks the URAM pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_tag <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_sr[i] <= '0;
      inflight  <= '0;
    end else begin
      issue_tag.valid <= issue;
      issue_tag.last  <= issue && (remaining == LEN_WIDTH'(1));
      tag_sr[0]       <= issue_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  uram_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (SKID_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  ({tag_sr[RD_LATENCY-1].last, ram_dout_b}),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .rd_data  ({fifo_last, m_data}),
    .count    (fifo_count)
  );

  assign m_last = m_valid && fifo_last;

endmodule

// File: tb/tb_uram_burst_reader.sv
// Scoreboard bench for uram_burst_reader with a behavioural 3-cycle URAM model.
module tb_uram_burst_reader;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int LW  = 15;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  uram_burst_reader dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  // URAM read port: address sampled at an edge, data out LAT edges later.
  logic [DW-1:0] mem  [1 << AW];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[ram_addr_b];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout_b = pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb [$];
  logic [AW-1:0] addr_log [$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   ready_pct = 100;
  int unsigned   done_cnt = 0, valid_cnt = 0, words_seen = 0, lasts_seen = 0;
  int unsigned   issued = 0, max_out = 0;
  logic [AW-1:0] last_addr = '0;
  logic          first_seen = 1'b1;
  time           first_time = 0, last_done_time = 0;
  logic          stall_prev = 1'b0;
  logic [DW+1:0] prev_bundle = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1 m_ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: pops the scoreboard on every handshake and polices stream rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_addr_b != last_addr) begin
        issued++;
        last_addr = ram_addr_b;
        addr_log.push_back(ram_addr_b);
      end
      if (issued - words_seen > max_out) max_out = issued - words_seen;
      if (stall_prev)
        check("stall_hold", longint'({m_valid, m_last, m_data}), longint'(prev_bundle));
      if (m_valid && !first_seen) begin
        first_seen = 1'b1;
        first_time = $time;
      end
      if (m_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        last_done_time = $time;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", longint'(m_data), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", longint'(m_data), longint'(e.data));
          check("last", longint'(m_last), longint'(e.last));
        end
        words_seen++;
        if (m_last) lasts_seen++;
      end
    end
    stall_prev  = !rst && m_valid && !m_ready;
    prev_bundle = {m_valid, m_last, m_data};
  end

  // Queues the reference words, then holds cmd_valid until the command is taken.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output time ta);
    int k;
    for (int i = 0; i < int'(l); i++)
      sb.push_back('{data: mem[(int'(a) + i) % (1 << AW)], last: (i == int'(l) - 1)});
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    ta = $time;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("done_wait", longint'(done_cnt >= target), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    time           ta, ta2;
    int unsigned   d0, v0, w0, l0;
    logic [AW-1:0] wrap_exp [4];
    wrap_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("reset_state",
          longint'({cmd_ready, m_valid, m_last, busy, done, ram_addr_b, m_data}),
          longint'(1) << 50);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Basic burst with latency
    d0 = done_cnt; l0 = lasts_seen;
    first_seen = 1'b0;
    send_cmd(14'h010, 15'd4, ta);
    wait_done(d0 + 1);
    check("first_valid_latency", longint'((first_time - ta - 5) / 10), 5);
    check("basic_done_count", longint'(done_cnt - d0), 1);
    check("basic_last_count", longint'(lasts_seen - l0), 1);
    check("basic_sb_empty", longint'(sb.size()), 0);

    // Address wrap
    d0 = done_cnt;
    addr_log.delete();
    send_cmd(14'h3FFE, 15'd4, ta);
    wait_done(d0 + 1);
    for (int i = 0; i < 4; i++)
      check("wrap_addr", (addr_log.size() > i) ? longint'(addr_log[i]) : -1,
            longint'(wrap_exp[i]));
    check("wrap_sb_empty", longint'(sb.size()), 0);

    // Backpressure
    d0 = done_cnt; issued = 0; words_seen = 0; max_out = 0;
    ready_pct = 30;
    send_cmd(14'h200, 15'd16, ta);
    wait_done(d0 + 1);
    ready_pct = 100;
    check("bp_words", longint'(words_seen), 16);
    check("bp_outstanding_le_8", longint'(max_out <= 8), 1);
    check("bp_sb_empty", longint'(sb.size()), 0);

    // Zero-length command
    d0 = done_cnt;
    send_cmd(14'h055, 15'd0, ta);
    @(negedge clk);
    check("zero_len_cycle1", longint'({done, cmd_ready}), 2);
    v0 = valid_cnt;
    @(negedge clk);
    check("zero_len_cycle2", longint'({done, cmd_ready}), 1);
    repeat (10) @(negedge clk);
    check("zero_len_no_data", longint'(valid_cnt - v0), 0);
    check("zero_len_done_count", longint'(done_cnt - d0), 1);
    @(posedge clk); #1;

    // Reset in the middle of a burst
    d0 = done_cnt; words_seen = 0;
    send_cmd(14'h1000, 15'd32, ta);
    begin
      int k;
      k = 0;
      while (words_seen < 3 && k < 200) begin
        @(posedge clk);
        k++;
      end
      check("abort_third_word", longint'(words_seen >= 3), 1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", longint'({m_valid, busy, cmd_ready}), 1);
    sb.delete();
    repeat (10) @(negedge clk);
    check("abort_no_done", longint'(done_cnt - d0), 0);
    @(posedge clk); #1;
    w0 = words_seen;
    send_cmd(14'h000, 15'd2, ta);
    wait_done(d0 + 1);
    check("post_abort_words", longint'(words_seen - w0), 2);
    check("post_abort_sb_empty", longint'(sb.size()), 0);

    // Back-to-back commands
    d0 = done_cnt; l0 = lasts_seen; w0 = words_seen;
    send_cmd(14'h300, 15'd3, ta);
    send_cmd(14'h400, 15'd2, ta2);
    check("second_accept_after_done",
          longint'((last_done_time > ta) && (ta2 > last_done_time)), 1);
    wait_done(d0 + 2);
    check("b2b_words", longint'(words_seen - w0), 5);
    check("b2b_lasts", longint'(lasts_seen - l0), 2);
    check("b2b_sb_empty", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
